// File: rtl/ps2_host_tx_pkg.sv
// ps2_host_tx_pkg: shared definitions for the PS/2 host-to-device transmitter
// and the scan-code receiver.
//   state_t      transmitter FSM encodings
//   err_code_t   completion status reported on err_code
//   DEF_*        default timing in 100 MHz clock cycles
//   CMD_*/RSP_*  keyboard command bytes and the device ACK byte
package ps2_host_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_REQ       = 3'd2,
      ST_BITS      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5,
      ST_DONE      = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK      = 2'b00,
      ERR_CLK_TO  = 2'b01,
      ERR_NACK    = 2'b10,
      ERR_IDLE_TO = 2'b11
   } err_code_t;

   localparam int CNT_W                = 18;
   localparam int DEF_INHIBIT_CYCLES   = 12000;   // 120 us
   localparam int DEF_SETUP_CYCLES     = 500;     // 5 us
   localparam int DEF_TIMEOUT_CYCLES   = 200000;  // 2 ms

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] RSP_ACK     = 8'hFA;

   // PS/2 uses odd parity: data bits plus parity hold an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a caller and ps2_host_tx.
//   tx_valid/tx_data  caller -> transmitter, byte accepted when tx_ready is high
//   tx_ready/busy     transmitter idle / transfer in progress
//   tx_done/tx_err    one-cycle completion pulse and failure flag
//   err_code          completion status, held until the next accept
interface ps2_host_tx_if;
   import ps2_host_tx_pkg::*;

   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       busy;
   logic       tx_done;
   logic       tx_err;
   err_code_t  err_code;

   modport master (output tx_valid, tx_data,
                   input  tx_ready, busy, tx_done, tx_err, err_code);
   modport slave  (input  tx_valid, tx_data,
                   output tx_ready, busy, tx_done, tx_err, err_code);
endinterface

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer plus registered falling-edge strobe for
// one open-collector PS/2 line. Shared by the transmitter and the receiver.
//   clk, rst  system clock, synchronous active-high reset
//   pin       raw asynchronous line value
//   lvl       synchronized level
//   fall      one-cycle strobe, 3 cycles after the pin falls
module ps2_line_sync (
   input  logic clk,
   input  logic rst,
   input  logic pin,
   output logic lvl,
   output logic fall
);
   logic [2:0] sh;

   // Flops reset to 1 (idle bus level) so reset never produces a fall.
   always_ff @(posedge clk) begin
      if (rst) begin
         sh   <= 3'b111;
         fall <= 1'b0;
      end else begin
         sh   <= {sh[1:0], pin};
         fall <= sh[2] & ~sh[1];
      end
   end

   assign lvl = sh[1];
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter. Runs the request-to-send
// handshake, shifts out {stop, parity, data} on device clock falls, checks
// the device ACK and waits for the bus to return idle.
//   clk, rst                  system clock, synchronous active-high reset
//   tx                        command handshake (slave side)
//   ps2_clk_in, ps2_data_in   raw line values
//   ps2_clk_oe, ps2_data_oe   1 = pull the line low, 0 = release
module ps2_host_tx
   import ps2_host_tx_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic             clk,
   input  logic             rst,
   ps2_host_tx_if.slave     tx,
   input  logic             ps2_clk_in,
   input  logic             ps2_data_in,
   output logic             ps2_clk_oe,
   output logic             ps2_data_oe
);
   localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

   logic clk_lvl, clk_fall, data_lvl, data_fall_unused;

   ps2_line_sync u_clk_sync (
      .clk(clk), .rst(rst), .pin(ps2_clk_in), .lvl(clk_lvl), .fall(clk_fall)
   );
   ps2_line_sync u_data_sync (
      .clk(clk), .rst(rst), .pin(ps2_data_in), .lvl(data_lvl), .fall(data_fall_unused)
   );

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;      // inhibit/setup length and fall timeout
   logic [3:0]       bit_cnt, bit_cnt_nx;
   logic [9:0]       frame, frame_nx;  // {stop, parity, data}
   logic             data_q, data_q_nx;
   err_code_t        err_q, err_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_cnt <= '0;
         frame   <= '0;
         data_q  <= 1'b0;
         err_q   <= ERR_OK;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         bit_cnt <= bit_cnt_nx;
         frame   <= frame_nx;
         data_q  <= data_q_nx;
         err_q   <= err_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_cnt_nx = bit_cnt;
      frame_nx   = frame;
      data_q_nx  = data_q;
      err_nx     = err_q;
      unique case (state)
         ST_IDLE: begin
            if (tx.tx_valid) begin
               state_nx   = ST_INHIBIT;
               cnt_nx     = '0;
               bit_cnt_nx = '0;
               frame_nx   = {1'b1, odd_parity(tx.tx_data), tx.tx_data};
               err_nx     = ERR_OK;
            end
         end
         ST_INHIBIT: begin
            if (cnt == INH_LAST) begin
               state_nx = ST_REQ;
               cnt_nx   = '0;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_REQ: begin
            // Leaving REQ releases the clock with data still low: start bit.
            if (cnt == SETUP_LAST) begin
               state_nx   = ST_BITS;
               cnt_nx     = '0;
               bit_cnt_nx = '0;
               data_q_nx  = 1'b1;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_BITS: begin
            // Fall n (1..10) presents frame[n-1]; a fall beats a timeout.
            if (clk_fall) begin
               cnt_nx     = '0;
               data_q_nx  = ~frame[bit_cnt];
               bit_cnt_nx = bit_cnt + 1'b1;
               if (bit_cnt == 4'd9) state_nx = ST_ACK;
            end else if (cnt == TO_LAST) begin
               state_nx  = ST_DONE;
               data_q_nx = 1'b0;
               err_nx    = ERR_CLK_TO;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_ACK: begin
            if (clk_fall) begin
               state_nx = ST_WAIT_IDLE;
               cnt_nx   = '0;
               err_nx   = data_lvl ? ERR_NACK : ERR_OK;
            end else if (cnt == TO_LAST) begin
               state_nx = ST_DONE;
               err_nx   = ERR_CLK_TO;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_WAIT_IDLE: begin
            if (clk_lvl && data_lvl) state_nx = ST_DONE;
            else if (cnt == TO_LAST) begin
               state_nx = ST_DONE;
               err_nx   = ERR_IDLE_TO;
            end else cnt_nx = cnt + 1'b1;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Line drives decode from the state so an error exit releases the bus
   // as soon as the FSM leaves BITS/ACK.
   assign ps2_clk_oe  = (state == ST_INHIBIT) || (state == ST_REQ);
   assign ps2_data_oe = (state == ST_REQ) || ((state == ST_BITS) && data_q);

   assign tx.tx_ready = (state == ST_IDLE);
   assign tx.busy     = (state != ST_IDLE);
   assign tx.tx_done  = (state == ST_DONE);
   assign tx.tx_err   = (state == ST_DONE) && (err_q != ERR_OK);
   assign tx.err_code = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a small PS/2 device
// model on wired-AND clock and data lines. Timing parameters are shrunk.
module tb_ps2_host_tx;
   localparam int INH = 30;
   localparam int SET = 10;
   localparam int TO  = 100;
   localparam int H   = 8;     // device clock half period, in system cycles

   logic clk, rst;
   logic clk_oe, data_oe;
   logic dev_clk, dev_data;
   logic clk_line, data_line;
   int   n_cmp, n_bad, n_done;
   int   c, n;
   logic [9:0] bits;
   int   done_before;

   ps2_host_tx_if tx_if ();

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .SETUP_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .tx(tx_if),
      .ps2_clk_in(clk_line), .ps2_data_in(data_line),
      .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe)
   );

   assign clk_line  = clk_oe  ? 1'b0 : dev_clk;
   assign data_line = data_oe ? 1'b0 : dev_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) if (tx_if.tx_done === 1'b1) n_done <= n_done + 1;

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = b;
      tick;
      tx_if.tx_valid = 1'b0;
      tx_if.tx_data  = 8'h5A;   // post-accept change must not matter
   endtask

   task automatic wait_release(output int cnt);
      cnt = 0;
      while (clk_oe === 1'b1 && cnt < 1000) begin cnt++; tick; end
   endtask

   task automatic wait_done(input int limit, output int cnt);
      cnt = 0;
      while (tx_if.tx_done !== 1'b1 && cnt < limit) begin cnt++; tick; end
      check("done_seen", tx_if.tx_done, 1'b1);
   endtask

   // Device: clocks nfalls falls, samples host data on each rise.
   // On fall 11 it pulls data low if ack; hold keeps data low afterwards.
   task automatic dev_frame(input int nfalls, input bit ack, input bit hold,
                            input bit poke, output logic [9:0] b);
      b = '0;
      repeat (H) tick;
      for (int k = 1; k <= nfalls; k++) begin
         if (k == 11 && ack) begin dev_data = 1'b0; repeat (2) tick; end
         dev_clk = 1'b0;
         if (poke && k == 3) begin
            tx_if.tx_valid = 1'b1;
            tx_if.tx_data  = 8'h00;
            check("ready_low_busy", tx_if.tx_ready, 1'b0);
            tick;
            tx_if.tx_valid = 1'b0;
            repeat (H - 1) tick;
         end else repeat (H) tick;
         dev_clk = 1'b1;
         if (k <= 10) b[k-1] = data_line;
         if (k == 11) begin
            if (!hold) dev_data = 1'b1;
         end else repeat (H) tick;
      end
   endtask

   initial begin
      n_cmp = 0; n_bad = 0; n_done = 0;
      rst = 1'b1; dev_clk = 1'b1; dev_data = 1'b1;
      tx_if.tx_valid = 1'b0; tx_if.tx_data = 8'h00;
      repeat (3) tick;
      rst = 1'b0;
      tick;
      // Reset state
      check("rst_clk_oe", clk_oe, 1'b0);
      check("rst_data_oe", data_oe, 1'b0);
      check("rst_busy", tx_if.busy, 1'b0);
      check("rst_ready", tx_if.tx_ready, 1'b1);
      check("rst_done", tx_if.tx_done, 1'b0);
      check("rst_err", tx_if.tx_err, 1'b0);
      check("rst_code", tx_if.err_code, 2'b00);

      // 1: 0xED with ACK, tx_valid poked during BITS
      check("idle_clk_oe", clk_oe, 1'b0);
      send(8'hED);
      check("accept_to_drive", clk_oe, 1'b1);
      check("inhibit_data_oe", data_oe, 1'b0);
      wait_release(c);
      check("ed_clk_oe_len", c, INH + SET);
      check("ed_start_bit", data_oe, 1'b1);
      check("ed_busy", tx_if.busy, 1'b1);
      dev_frame(11, 1'b1, 1'b0, 1'b1, bits);
      check("ed_bits", bits, 10'h3ED);
      wait_done(50, n);
      check("ed_err", tx_if.tx_err, 1'b0);
      check("ed_code", tx_if.err_code, 2'b00);
      check("ed_busy_at_done", tx_if.busy, 1'b1);
      check("ed_ready_at_done", tx_if.tx_ready, 1'b0);
      tick;
      check("ed_done_pulse", tx_if.tx_done, 1'b0);
      check("ed_busy_after", tx_if.busy, 1'b0);
      check("ed_ready_after", tx_if.tx_ready, 1'b1);
      repeat (5) tick;
      check("ed_done_count", n_done, 1);

      // 2: 0xFF, device NACKs
      send(8'hFF);
      wait_release(c);
      dev_frame(11, 1'b0, 1'b0, 1'b0, bits);
      check("ff_bits", bits, 10'h3FF);
      wait_done(50, n);
      check("ff_code", tx_if.err_code, 2'b10);
      check("ff_err", tx_if.tx_err, 1'b1);
      tick;
      check("ff_clk_oe", clk_oe, 1'b0);
      check("ff_data_oe", data_oe, 1'b0);
      check("ff_code_held", tx_if.err_code, 2'b10);
      check("ff_err_cleared", tx_if.tx_err, 1'b0);

      // 3: 0xF4, no device clock at all
      repeat (3) tick;
      send(8'hF4);
      wait_release(c);
      check("to_clk_oe_len", c, INH + SET);
      wait_done(500, n);
      check("to_latency", n, TO);
      check("to_code", tx_if.err_code, 2'b01);
      check("to_err", tx_if.tx_err, 1'b1);
      tick;
      check("to_data_oe", data_oe, 1'b0);

      // 4: reset after fall 4 of 0x00
      repeat (3) tick;
      send(8'h00);
      wait_release(c);
      dev_frame(4, 1'b0, 1'b0, 1'b0, bits);
      check("rs_data_oe_pre", data_oe, 1'b1);
      done_before = n_done;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      check("rs_clk_oe", clk_oe, 1'b0);
      check("rs_data_oe", data_oe, 1'b0);
      check("rs_ready", tx_if.tx_ready, 1'b1);
      check("rs_code", tx_if.err_code, 2'b00);
      repeat (TO + 20) tick;
      check("rs_no_done", n_done, done_before);

      // 5: 0xF4 with ACK, device keeps data low afterwards
      send(8'hF4);
      wait_release(c);
      dev_frame(11, 1'b1, 1'b1, 1'b0, bits);
      check("it_bits", bits, 10'h2F4);
      wait_done(300, n);
      check("it_code", tx_if.err_code, 2'b11);
      check("it_err", tx_if.tx_err, 1'b1);
      dev_data = 1'b1;
      repeat (5) tick;
      check("total_done_count", n_done, 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
